// File: rtl/systolic_sequencer.sv
// Feed/control sequencer for an NxN systolic array: buffers one A and one B tile,
// then runs clear -> weight load -> skewed activation injection -> drain.
module systolic_sequencer #(
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned ARRAY_SIZE   = 4,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  start,
  input  logic                                  a_wr_en,
  input  logic [$clog2(ARRAY_SIZE)-1:0]         a_wr_row,
  input  logic [$clog2(ARRAY_SIZE)-1:0]         a_wr_col,
  input  logic [DATA_BITS-1:0]                  a_wr_data,
  input  logic                                  b_wr_en,
  input  logic [$clog2(ARRAY_SIZE)-1:0]         b_wr_row,
  input  logic [$clog2(ARRAY_SIZE)-1:0]         b_wr_col,
  input  logic [DATA_BITS-1:0]                  b_wr_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  clear_acc,
  output logic                                  load_weights,
  output logic                                  compute_enable,
  output logic [ARRAY_SIZE-1:0][DATA_BITS-1:0]  a_inputs,
  output logic [ARRAY_SIZE-1:0][DATA_BITS-1:0]  b_inputs
);

  localparam int unsigned IDX_W       = $clog2(ARRAY_SIZE);
  localparam int unsigned COMP_CYCLES = 2 * ARRAY_SIZE - 1;
  localparam int unsigned CNT_MAX     = (COMP_CYCLES > DRAIN_CYCLES) ? COMP_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

  typedef logic [ARRAY_SIZE-1:0][DATA_BITS-1:0] edge_vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_BITS-1:0] a_buf [ARRAY_SIZE][ARRAY_SIZE];
  logic [DATA_BITS-1:0] b_buf [ARRAY_SIZE][ARRAY_SIZE];

  // North-edge word for load step k: rows go in bottom-first so row 0 lands on top.
  function automatic edge_vec_t b_row(input int unsigned k);
    edge_vec_t v;
    v = '0;
    for (int unsigned c = 0; c < ARRAY_SIZE; c++)
      v[IDX_W'(c)] = b_buf[IDX_W'(ARRAY_SIZE - 1 - k)][IDX_W'(c)];
    return v;
  endfunction

  // West-edge wavefront at compute step t: row r lags by r cycles.
  function automatic edge_vec_t a_wave(input int unsigned t);
    edge_vec_t v;
    v = '0;
    for (int unsigned r = 0; r < ARRAY_SIZE; r++)
      if (t >= r && (t - r) < ARRAY_SIZE)
        v[IDX_W'(r)] = a_buf[IDX_W'(t - r)][IDX_W'(r)];
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      clear_acc      <= 1'b0;
      load_weights   <= 1'b0;
      compute_enable <= 1'b0;
      a_inputs       <= '0;
      b_inputs       <= '0;
      for (int unsigned r = 0; r < ARRAY_SIZE; r++)
        for (int unsigned c = 0; c < ARRAY_SIZE; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (a_wr_en) a_buf[a_wr_row][a_wr_col] <= a_wr_data;
          if (b_wr_en) b_buf[b_wr_row][b_wr_col] <= b_wr_data;
          if (start) begin
            state     <= S_CLEAR;
            busy      <= 1'b1;
            clear_acc <= 1'b1;
          end
        end
        S_CLEAR: begin
          state        <= S_LOAD;
          cnt          <= '0;
          clear_acc    <= 1'b0;
          load_weights <= 1'b1;
          b_inputs     <= b_row(0);
        end
        S_LOAD: begin
          if (cnt == CNT_W'(ARRAY_SIZE - 1)) begin
            state          <= S_COMPUTE;
            cnt            <= '0;
            load_weights   <= 1'b0;
            compute_enable <= 1'b1;
            b_inputs       <= '0;
            a_inputs       <= a_wave(0);
          end else begin
            cnt      <= cnt + 1'b1;
            b_inputs <= b_row(32'(cnt) + 32'd1);
          end
        end
        S_COMPUTE: begin
          if (cnt == CNT_W'(COMP_CYCLES - 1)) begin
            state    <= S_DRAIN;
            cnt      <= '0;
            a_inputs <= '0;
          end else begin
            cnt      <= cnt + 1'b1;
            a_inputs <= a_wave(32'(cnt) + 32'd1);
          end
        end
        S_DRAIN: begin
          if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
            state          <= S_DONE;
            cnt            <= '0;
            compute_enable <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state          <= S_IDLE;
          cnt            <= '0;
          busy           <= 1'b0;
          done           <= 1'b0;
          clear_acc      <= 1'b0;
          load_weights   <= 1'b0;
          compute_enable <= 1'b0;
          a_inputs       <= '0;
          b_inputs       <= '0;
        end
      endcase
    end
  end

endmodule
